// File: rtl/dmem_responder.sv
// Multi-cycle doubleword data-memory responder for the MEM-stage port.
// Accepts one request in IDLE, counts the access latency, then answers with a one-cycle pulse.
module dmem_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          READ_LAT  = 2,
    parameter int          WRITE_LAT = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        ReadValid,
    output logic        WriteDone,
    output logic        AddrFault,
    output logic        Busy
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [63:0]      r_wdata;
    logic [63:0]      r_mem [DEPTH];

    logic             w_req;
    logic             w_fault;
    logic             w_commit;
    logic [64:0]      w_diff;
    logic [IDX_W-1:0] w_idx;

    // One 65-bit subtraction yields both range checks: the borrow flags an address
    // below the base, any bit above the index field flags one past the top word.
    assign w_diff   = {1'b0, Address} - {1'b0, BASE_ADDR};
    assign w_idx    = w_diff[IDX_W+2:3];
    assign w_req    = MemoryRead | MemoryWrite;
    assign w_fault  = (MemoryRead & MemoryWrite)
                    | (w_diff[2:0] != 3'd0)
                    | w_diff[64]
                    | (w_diff[63:IDX_W+3] != '0);
    assign w_commit = (r_state == S_WR_WAIT) && (r_cnt == '0);
    assign Busy     = (r_state != S_IDLE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            ReadData  <= '0;
            ReadValid <= 1'b0;
            WriteDone <= 1'b0;
            AddrFault <= 1'b0;
        end else begin
            ReadValid <= 1'b0;
            WriteDone <= 1'b0;
            AddrFault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_fault) begin
                            r_state   <= S_RESP;
                            AddrFault <= 1'b1;
                        end else begin
                            r_idx   <= w_idx;
                            r_wdata <= WriteData;
                            if (MemoryRead) begin
                                r_state <= S_RD_WAIT;
                                r_cnt   <= CNT_W'(READ_LAT - 1);
                            end else begin
                                r_state <= S_WR_WAIT;
                                r_cnt   <= CNT_W'(WRITE_LAT - 1);
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        ReadData  <= r_mem[r_idx];
                        ReadValid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (r_cnt == '0) begin
                        WriteDone <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; gating on Rst keeps an abandoned write from landing.
    always_ff @(posedge Clk) begin
        if (w_commit && !Rst) r_mem[r_idx] <= r_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// accesses compared against a plain array/latency model of the responder.
module tb_dmem_responder;
    localparam int          DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          RL    = 2;
    localparam int          WL    = 3;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        MemoryRead, MemoryWrite;
    logic [63:0] Address, WriteData, ReadData;
    logic        ReadValid, WriteDone, AddrFault, Busy;

    int errors = 0;
    int checks = 0;

    // Reference model: array contents and last successful read.
    logic [63:0] mdl_mem [DEPTH];
    logic [63:0] mdl_rd;

    // Observations of the most recent access.
    int o_lat, o_busy, o_pulses;
    bit o_rv, o_wd, o_af;

    dmem_responder #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(RL), .WRITE_LAT(WL)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .ReadValid(ReadValid), .WriteDone(WriteDone),
        .AddrFault(AddrFault), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // 0 = fault, 1 = read, 2 = write
    function automatic int mdl_kind(bit rd, bit wr, logic [63:0] a);
        if (rd && wr) return 0;
        if ((a % 64'd8) != 0) return 0;
        if (a < BASE || a >= BASE + 64'(8 * DEPTH)) return 0;
        return rd ? 1 : 2;
    endfunction

    function automatic int mdl_idx(logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    function automatic int mdl_lat(int kind);
        return (kind == 1) ? RL : (kind == 2) ? WL : 0;
    endfunction

    function automatic void mdl_apply(bit rd, bit wr, logic [63:0] a, logic [63:0] d);
        int k;
        k = mdl_kind(rd, wr, a);
        if (k == 1) mdl_rd = mdl_mem[mdl_idx(a)];
        if (k == 2) mdl_mem[mdl_idx(a)] = d;
    endfunction

    function automatic logic [63:0] waddr(int idx);
        return BASE + 64'(idx) * 64'd8;
    endfunction

    // Present one request for a single acceptance edge, then watch until Busy drops.
    // With noise set, the request lines and address are scrambled while busy.
    task automatic access(input bit rd, input bit wr, input logic [63:0] a,
                          input logic [63:0] d, input bit noise);
        @(negedge Clk);
        MemoryRead = rd; MemoryWrite = wr; Address = a; WriteData = d;
        @(posedge Clk);
        #1;
        MemoryRead = 1'b0; MemoryWrite = 1'b0;
        Address = {$urandom, $urandom}; WriteData = {$urandom, $urandom};
        o_lat = -1; o_busy = 0; o_pulses = 0; o_rv = 0; o_wd = 0; o_af = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (!Busy) break;
            o_busy++;
            if (ReadValid || WriteDone || AddrFault) begin
                o_pulses++;
                o_lat = k;
                o_rv |= ReadValid; o_wd |= WriteDone; o_af |= AddrFault;
                MemoryRead = 1'b0; MemoryWrite = 1'b0;
            end else if (noise) begin
                MemoryWrite = 1'($urandom);
                Address     = {$urandom, $urandom};
                WriteData   = {$urandom, $urandom};
            end
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1; MemoryRead = 1'b0; MemoryWrite = 1'b0; Address = '0; WriteData = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({ReadData, ReadValid, WriteDone, AddrFault, Busy} !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%h rv=%b wd=%b af=%b busy=%b expected all 0",
                     ReadData, ReadValid, WriteDone, AddrFault, Busy);
        end
        Rst = 1'b0;
        mdl_rd = '0;
    endtask

    task automatic test_fill;
        logic [63:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = {$urandom, $urandom};
            access(1'b0, 1'b1, waddr(i), d, 1'b0);
            mdl_apply(1'b0, 1'b1, waddr(i), d);
            checks++;
            if (!(o_wd && !o_rv && !o_af && o_pulses == 1 && o_lat == WL && o_busy == WL + 1)) begin
                errors++;
                $display("FAIL fill_write[%0d]: got wd=%b lat=%0d busy=%0d pulses=%0d expected wd=1 lat=%0d busy=%0d pulses=1",
                         i, o_wd, o_lat, o_busy, o_pulses, WL, WL + 1);
            end
        end
    endtask

    task automatic test_write_read;
        access(1'b0, 1'b1, BASE + 64'd8, 64'hDEAD_BEEF_0123_4567, 1'b0);
        mdl_apply(1'b0, 1'b1, BASE + 64'd8, 64'hDEAD_BEEF_0123_4567);
        checks++;
        if (!(o_wd && o_lat == WL && o_busy == WL + 1 && o_pulses == 1)) begin
            errors++;
            $display("FAIL wr_timing: got wd=%b lat=%0d busy=%0d expected wd=1 lat=%0d busy=%0d",
                     o_wd, o_lat, o_busy, WL, WL + 1);
        end
        access(1'b1, 1'b0, BASE + 64'd8, 64'h0, 1'b0);
        mdl_apply(1'b1, 1'b0, BASE + 64'd8, 64'h0);
        checks++;
        if (!(o_rv && o_lat == RL && o_busy == RL + 1 && o_pulses == 1)) begin
            errors++;
            $display("FAIL rd_timing: got rv=%b lat=%0d busy=%0d expected rv=1 lat=%0d busy=%0d",
                     o_rv, o_lat, o_busy, RL, RL + 1);
        end
        checks++;
        if (ReadData !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL rd_after_wr: got %h expected %h", ReadData, 64'hDEAD_BEEF_0123_4567);
        end
    endtask

    task automatic test_faults;
        logic [63:0] fa [4];
        bit          frd [4];
        bit          fwr [4];
        fa[0] = BASE + 64'd4;            frd[0] = 1; fwr[0] = 0;
        fa[1] = BASE + 64'(8 * DEPTH);   frd[1] = 1; fwr[1] = 0;
        fa[2] = BASE + 64'd16;           frd[2] = 1; fwr[2] = 1;
        fa[3] = BASE - 64'd8;            frd[3] = 0; fwr[3] = 1;
        for (int i = 0; i < 4; i++) begin
            access(frd[i], fwr[i], fa[i], 64'hFFFF_0000_FFFF_0000, 1'b0);
            checks++;
            if (!(o_af && !o_rv && !o_wd && o_lat == 0 && o_busy == 1 && o_pulses == 1)) begin
                errors++;
                $display("FAIL fault[%0d]: got af=%b rv=%b wd=%b lat=%0d busy=%0d expected af=1 rv=0 wd=0 lat=0 busy=1",
                         i, o_af, o_rv, o_wd, o_lat, o_busy);
            end
            checks++;
            if (ReadData !== mdl_rd) begin
                errors++;
                $display("FAIL fault_rd_hold[%0d]: got %h expected %h", i, ReadData, mdl_rd);
            end
        end
        access(1'b1, 1'b0, BASE + 64'd16, 64'h0, 1'b0);
        mdl_apply(1'b1, 1'b0, BASE + 64'd16, 64'h0);
        checks++;
        if (ReadData !== mdl_rd || !o_rv) begin
            errors++;
            $display("FAIL fault_target_word: got %h expected %h", ReadData, mdl_rd);
        end
    endtask

    task automatic test_boundary;
        access(1'b0, 1'b1, waddr(DEPTH - 1), 64'h1, 1'b0);
        mdl_apply(1'b0, 1'b1, waddr(DEPTH - 1), 64'h1);
        access(1'b1, 1'b0, waddr(DEPTH - 1), 64'h0, 1'b0);
        mdl_apply(1'b1, 1'b0, waddr(DEPTH - 1), 64'h0);
        checks++;
        if (!o_rv || ReadData !== 64'h1) begin
            errors++;
            $display("FAIL top_word: got rv=%b data=%h expected rv=1 data=%h", o_rv, ReadData, 64'h1);
        end
        access(1'b1, 1'b0, waddr(0), 64'h0, 1'b0);
        mdl_apply(1'b1, 1'b0, waddr(0), 64'h0);
        checks++;
        if (!o_rv || ReadData !== mdl_rd) begin
            errors++;
            $display("FAIL bottom_word: got rv=%b data=%h expected rv=1 data=%h", o_rv, ReadData, mdl_rd);
        end
    endtask

    task automatic test_back_to_back;
        int npulse;
        @(negedge Clk);
        MemoryRead = 1'b1; MemoryWrite = 1'b0; Address = waddr(5);
        npulse = 0;
        for (int c = 0; c < 60 && npulse < 7; c++) begin
            @(negedge Clk);
            if (ReadValid) begin
                checks++;
                if (c != RL + npulse * (RL + 2) || ReadData !== mdl_mem[5]) begin
                    errors++;
                    $display("FAIL b2b_pulse[%0d]: got cycle=%0d data=%h expected cycle=%0d data=%h",
                             npulse, c, ReadData, RL + npulse * (RL + 2), mdl_mem[5]);
                end
                npulse++;
                if (npulse == 7) MemoryRead = 1'b0;
            end
        end
        MemoryRead = 1'b0;
        mdl_rd = mdl_mem[5];
        checks++;
        if (npulse != 7) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses expected 7", npulse);
        end
        for (int k = 0; k < 10 && Busy; k++) @(negedge Clk);
    endtask

    task automatic test_rst_mid_write;
        logic [63:0] old;
        old = mdl_mem[3];
        @(negedge Clk);
        MemoryWrite = 1'b1; MemoryRead = 1'b0; Address = waddr(3); WriteData = ~old;
        @(posedge Clk);
        #1;
        MemoryWrite = 1'b0;
        @(negedge Clk);
        checks++;
        if (!(Busy && !WriteDone)) begin
            errors++;
            $display("FAIL rst_pre: got busy=%b wd=%b expected busy=1 wd=0", Busy, WriteDone);
        end
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        checks++;
        if ({ReadData, ReadValid, WriteDone, AddrFault, Busy} !== 68'd0) begin
            errors++;
            $display("FAIL rst_immediate: got rd=%h rv=%b wd=%b af=%b busy=%b expected all 0",
                     ReadData, ReadValid, WriteDone, AddrFault, Busy);
        end
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({WriteDone, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_hold: got wd=%b busy=%b expected 0 0", WriteDone, Busy);
        end
        Rst = 1'b0;
        mdl_rd = '0;
        access(1'b1, 1'b0, waddr(3), 64'h0, 1'b0);
        mdl_apply(1'b1, 1'b0, waddr(3), 64'h0);
        checks++;
        if (!o_rv || ReadData !== old) begin
            errors++;
            $display("FAIL rst_abandoned_write: got rv=%b data=%h expected rv=1 data=%h", o_rv, ReadData, old);
        end
    endtask

    task automatic test_noise_read;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, waddr(6 + i), 64'h0, 1'b1);
            mdl_apply(1'b1, 1'b0, waddr(6 + i), 64'h0);
            checks++;
            if (!o_rv || o_lat != RL || ReadData !== mdl_rd) begin
                errors++;
                $display("FAIL noise_read[%0d]: got rv=%b lat=%0d data=%h expected rv=1 lat=%0d data=%h",
                         i, o_rv, o_lat, ReadData, RL, mdl_rd);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 1'b0, waddr(i), 64'h0, 1'b0);
            mdl_apply(1'b1, 1'b0, waddr(i), 64'h0);
            checks++;
            if (!o_rv || ReadData !== mdl_rd) begin
                errors++;
                $display("FAIL sweep[%0d]: got rv=%b data=%h expected rv=1 data=%h", i, o_rv, ReadData, mdl_rd);
            end
        end
    endtask

    task automatic test_random;
        bit          rd, wr;
        logic [63:0] a, d;
        int          kind, sel;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            rd  = 1'($urandom);
            wr  = !rd;
            if (sel == 0) begin rd = 1; wr = 1; end
            a = waddr($urandom_range(0, DEPTH - 1));
            if (sel == 1) a = a + 64'($urandom_range(1, 7));
            if (sel == 2) a = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 3));
            if (sel == 3) a = BASE - 64'(8 * $urandom_range(1, 4));
            d    = {$urandom, $urandom};
            kind = mdl_kind(rd, wr, a);
            access(rd, wr, a, d, 1'($urandom));
            mdl_apply(rd, wr, a, d);
            checks++;
            if (o_pulses != 1 || {o_af, o_rv, o_wd} !== {kind == 0, kind == 1, kind == 2}) begin
                errors++;
                $display("FAIL rand_kind[%0d]: got af/rv/wd=%b%b%b pulses=%0d expected kind=%0d pulses=1",
                         n, o_af, o_rv, o_wd, o_pulses, kind);
            end
            checks++;
            if (o_lat != mdl_lat(kind) || o_busy != mdl_lat(kind) + 1) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                         n, o_lat, o_busy, mdl_lat(kind), mdl_lat(kind) + 1);
            end
            checks++;
            if (ReadData !== mdl_rd) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h expected %h", n, ReadData, mdl_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_faults();
        test_boundary();
        test_back_to_back();
        test_rst_mid_write();
        test_noise_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
